cra_sbr_stack: RTL and testbench

- CRAM subroutine call/return stack controller for the microsequencer.
- Saves the microcode return address on CALL or a forced trap to 1777, and restores it on a RETURN dispatch (DISP 00-03 selector 3).
- Presents the current top of stack as sbrRet to the CRAM address mux.
- Provides the stack pointer, depth and error flags for diagnostic EBUS readout.

---
 rtl/cra_sbr_stack.sv | 153 +++++++++++++++
 tb/tb_cra_sbr_stack.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/cra_sbr_stack.sv
// ---------------------------------------------------------------------------
// cra_sbr_stack
//
// This is the CRAM subroutine call/return stack for the microsequencer.
//
// A CALL, or a trap that forces CRADR to 1777, saves the current microcode
// address. A RETURN dispatch takes the top entry off the stack again. The
// current top entry is always available, registered, as sbrRet for the CRAM
// address mux. The pointer, the depth and two sticky error flags can be read
// back over EBUS for diagnostics.
//
// Ports
//   clk        system clock; all state changes on its rising edge
//   reset      synchronous active-high reset; overrides every other input
//   en         microinstruction-advance enable; when low, the stack holds
//   call       CRAM CALL bit
//   force1777  trap forcing of CRADR to 1777; acts as a call, suppresses ret
//   ret        RETURN dispatch decoded
//   pushAdr    address to save (current CRADR)
//   diaClr     diagnostic clear of the sticky flags only
//   sbrRet     registered top-of-stack entry
//   stackAdr   {depth==0, sp} for EBUS diagnostics
//   depth      number of valid entries, 0..DEPTH
//   overflow   sticky: a push happened while the stack was full
//   underflow  sticky: a pop happened while the stack was empty
// ---------------------------------------------------------------------------
module cra_sbr_stack #(
    parameter int DEPTH = 16,
    parameter int AW    = 11,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          call,
    input  logic          force1777,
    input  logic          ret,
    input  logic [AW-1:0] pushAdr,
    input  logic          diaClr,
    output logic [AW-1:0] sbrRet,
    output logic [PW:0]   stackAdr,
    output logic [PW:0]   depth,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    // Storage is cleared by reset, so it is built from flops, one entry per
    // generate slice, rather than from block RAM.
    logic [AW-1:0] mem_reg [DEPTH];

    logic [PW-1:0] sp_reg,        sp_next;
    logic [PW:0]   depth_reg,     depth_next;
    logic [AW-1:0] sbr_ret_reg,   sbr_ret_next;
    logic          overflow_reg,  overflow_next;
    logic          underflow_reg, underflow_next;

    logic          do_push, do_pop;
    logic          op_push, op_pop, op_repl;
    logic          wr_en;
    logic [PW-1:0] wr_ptr;

    // A trap suppresses the pop, so trap plus return is a plain push.
    assign do_push = en & (call | force1777);
    assign do_pop  = en & ret & ~force1777;

    assign op_push = do_push & ~do_pop;
    assign op_pop  = ~do_push & do_pop;
    assign op_repl = do_push & do_pop;

    always_comb begin
        sp_next        = sp_reg;
        depth_next     = depth_reg;
        wr_en          = 1'b0;
        wr_ptr         = sp_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        if (diaClr) begin
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end

        if (op_push) begin
            // sp wraps freely. On overflow the oldest entry gets overwritten.
            sp_next = sp_reg + 1'b1;
            wr_en   = 1'b1;
            wr_ptr  = sp_reg + 1'b1;
            if (depth_reg == FULL) begin
                overflow_next = 1'b1;   // a new error event beats diaClr
            end else begin
                depth_next = depth_reg + 1'b1;
            end
        end else if (op_pop) begin
            // sp still moves on underflow, so sbrRet then shows stale data.
            sp_next = sp_reg - 1'b1;
            if (depth_reg == '0) begin
                underflow_next = 1'b1;
            end else begin
                depth_next = depth_reg - 1'b1;
            end
        end else if (op_repl) begin
            // A return-and-call swaps the top entry in place.
            wr_en  = 1'b1;
            wr_ptr = sp_reg;
        end

        // Every write lands at the new sp, so the write data is forwarded
        // straight into the registered top-of-stack.
        if (wr_en) begin
            sbr_ret_next = pushAdr;
        end else begin
            sbr_ret_next = mem_reg[sp_next];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_reg[gi] <= '0;
                end else if (wr_en && (wr_ptr == PW'(gi))) begin
                    mem_reg[gi] <= pushAdr;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_reg        <= '0;
            depth_reg     <= '0;
            sbr_ret_reg   <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            depth_reg     <= depth_next;
            sbr_ret_reg   <= sbr_ret_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign sbrRet    = sbr_ret_reg;
    assign depth     = depth_reg;
    assign stackAdr  = {(depth_reg == '0), sp_reg};
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_cra_sbr_stack.sv
// ---------------------------------------------------------------------------
// tb_cra_sbr_stack
//
// Directed bench for the subroutine stack.
//
// Each step drives one set of inputs on the falling edge. At the same time it
// queues the outputs expected after the next rising edge. A separate monitor
// samples the outputs 1 ns after every rising edge and checks them against the
// queue.
// ---------------------------------------------------------------------------
module tb_cra_sbr_stack;

    logic        clk = 1'b0;
    logic        reset, en, call, force1777, ret, diaClr;
    logic [10:0] pushAdr;
    logic [10:0] sbrRet;
    logic [4:0]  stackAdr, depth;
    logic        overflow, underflow;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] x_ret;
        logic [4:0]  x_sadr;
        logic [4:0]  x_dep;
        logic        x_ov;
        logic        x_un;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    cra_sbr_stack #(.DEPTH(16), .AW(11), .PW(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .call      (call),
        .force1777 (force1777),
        .ret       (ret),
        .pushAdr   (pushAdr),
        .diaClr    (diaClr),
        .sbrRet    (sbrRet),
        .stackAdr  (stackAdr),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    // Drive one transaction and queue its expected result.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic f, input logic rt, input logic dc,
                        input logic [10:0] adr, input string nm,
                        input logic [10:0] xr, input logic [4:0] xs,
                        input logic [4:0] xd, input logic xo, input logic xu);
        exp_t x;
        @(negedge clk);
        reset = r; en = e; call = c; force1777 = f; ret = rt; diaClr = dc;
        pushAdr = adr;
        x.x_ret = xr; x.x_sadr = xs; x.x_dep = xd; x.x_ov = xo; x.x_un = xu;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    // Monitor: the stack presents a new state after every edge.
    initial begin
        exp_t  x;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                nm = name_q.pop_front();
                total += 5;
                if (sbrRet !== x.x_ret) begin
                    bad++;
                    $display("FAIL %s sbrRet got=%h want=%h", nm, sbrRet, x.x_ret);
                end
                if (stackAdr !== x.x_sadr) begin
                    bad++;
                    $display("FAIL %s stackAdr got=%h want=%h", nm, stackAdr, x.x_sadr);
                end
                if (depth !== x.x_dep) begin
                    bad++;
                    $display("FAIL %s depth got=%0d want=%0d", nm, depth, x.x_dep);
                end
                if (overflow !== x.x_ov) begin
                    bad++;
                    $display("FAIL %s overflow got=%b want=%b", nm, overflow, x.x_ov);
                end
                if (underflow !== x.x_un) begin
                    bad++;
                    $display("FAIL %s underflow got=%b want=%b", nm, underflow, x.x_un);
                end
                $display("txn %-12s sbrRet=%h stackAdr=%h depth=%0d ov=%b un=%b",
                         nm, sbrRet, stackAdr, depth, overflow, underflow);
            end
        end
    end

    initial begin
        logic [10:0] xr;
        int          sp_e;
        reset = 1'b1; en = 1'b0; call = 1'b0; force1777 = 1'b0;
        ret = 1'b0; diaClr = 1'b0; pushAdr = '0;

        // Reset first, then three pushes followed by three pops.
        //   args: r  e  c  f  rt dc adr     name         ret     sadr   dep ov un
        step(1, 1, 0, 0, 0, 0, 11'h000, "reset",  11'h000, 5'h10, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h123, "push123", 11'h123, 5'h01, 5'd1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h456, "push456", 11'h456, 5'h02, 5'd2, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h789, "push789", 11'h789, 5'h03, 5'd3, 0, 0);
        step(0, 1, 0, 0, 1, 0, 11'h000, "pop1",    11'h456, 5'h02, 5'd2, 0, 0);
        step(0, 1, 0, 0, 1, 0, 11'h000, "pop2",    11'h123, 5'h01, 5'd1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 11'h000, "pop3",    11'h000, 5'h10, 5'd0, 0, 0);

        // Overflow: 17 pushes starting from sp=0. The 17th push also asserts
        // diaClr, and the overflow event must still win.
        for (int k = 1; k <= 17; k++) begin
            step(0, 1, 1, 0, 0, (k == 17), 11'(k), $sformatf("ovpush%0d", k),
                 11'(k), {1'b0, 4'(k % 16)}, 5'((k > 16) ? 16 : k),
                 (k == 17), 0);
        end
        // Sixteen pops: 0x010, then 0x00F down to 0x002, then 0x011.
        for (int j = 1; j <= 16; j++) begin
            xr   = (j == 1) ? 11'h010 : (j == 16) ? 11'h011 : 11'(17 - j);
            sp_e = (17 - j) % 16;
            step(0, 1, 0, 0, 1, 0, 11'h000, $sformatf("ovpop%0d", j),
                 xr, {(j == 16), 4'(sp_e)}, 5'(16 - j), 1, 0);
        end

        // Replace: call and ret together while depth is 2. Reset is applied
        // with en and call high, and it must still win.
        step(1, 1, 1, 0, 0, 0, 11'h555, "reset2",  11'h000, 5'h10, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h100, "push100", 11'h100, 5'h01, 5'd1, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h200, "push200", 11'h200, 5'h02, 5'd2, 0, 0);
        step(0, 1, 1, 0, 1, 0, 11'h3FF, "repl3FF", 11'h3FF, 5'h02, 5'd2, 0, 0);

        // force1777 plus ret must act as a push. With en=0 the stack holds.
        step(1, 0, 0, 0, 0, 0, 11'h000, "reset3",  11'h000, 5'h10, 5'd0, 0, 0);
        step(0, 1, 1, 0, 0, 0, 11'h0AA, "push0AA", 11'h0AA, 5'h01, 5'd1, 0, 0);
        step(0, 1, 0, 1, 1, 0, 11'h7FF, "frcret",  11'h7FF, 5'h02, 5'd2, 0, 0);
        step(0, 0, 0, 1, 1, 0, 11'h555, "en0frc",  11'h7FF, 5'h02, 5'd2, 0, 0);
        step(0, 0, 0, 0, 1, 0, 11'h000, "en0pop",  11'h7FF, 5'h02, 5'd2, 0, 0);
        step(0, 0, 1, 0, 0, 0, 11'h111, "en0call", 11'h7FF, 5'h02, 5'd2, 0, 0);

        // Underflow, then clearing the flag, then clear and a new event
        // in the same cycle.
        step(1, 1, 0, 0, 0, 0, 11'h000, "reset4",  11'h000, 5'h10, 5'd0, 0, 0);
        step(0, 1, 0, 0, 1, 0, 11'h000, "unpop",   11'h000, 5'h1F, 5'd0, 0, 1);
        step(0, 1, 0, 0, 0, 1, 11'h000, "diaclr",  11'h000, 5'h1F, 5'd0, 0, 0);
        step(0, 1, 0, 0, 1, 1, 11'h000, "clrpop",  11'h000, 5'h1E, 5'd0, 0, 1);

        @(negedge clk);
        en = 1'b0; call = 1'b0; ret = 1'b0; force1777 = 1'b0; diaClr = 1'b0;

        // Wait, with a bound, for the monitor to drain the queue.
        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
